mandelbrot_engine: RTL and testbench



---
 rtl/mandelbrot_engine.sv | 151 +++++++++++++++
 tb/tb_mandelbrot_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mandelbrot_engine.sv
// Escape-time fractal engine: iterates z <- z^2 + c once per clock and reports the escape count.
// Optional macro MANDEL_ZOUT_EN exposes the terminating z value on o_z_re/o_z_im.
module mandelbrot_engine #(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 12,
    parameter int ITER_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_mode,
    input  logic signed [WIDTH-1:0]  i_p_re,
    input  logic signed [WIDTH-1:0]  i_p_im,
    input  logic signed [WIDTH-1:0]  i_k_re,
    input  logic signed [WIDTH-1:0]  i_k_im,
    input  logic [ITER_W-1:0]        i_max_iter,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ITER_W-1:0]        o_iter,
    output logic                     o_bounded
`ifdef MANDEL_ZOUT_EN
    ,
    output logic signed [WIDTH-1:0]  o_z_re,
    output logic signed [WIDTH-1:0]  o_z_im
`endif
);

    localparam int W2 = 2 * WIDTH;
    localparam logic signed [W2-1:0] ESC_LIM = {{(W2-FRAC-3){1'b0}}, 3'b100, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    function automatic logic signed [W2-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        logic signed [W2-1:0] prod;
        prod = W2'(a) * W2'(b);
        return prod >>> FRAC;
    endfunction

    function automatic logic signed [WIDTH-1:0] wrap_w(input logic signed [W2-1:0] x);
        return x[WIDTH-1:0];
    endfunction

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   z_re_q, z_re_d, z_im_q, z_im_d;
    logic signed [WIDTH-1:0]   c_re_q, c_re_d, c_im_q, c_im_d;
    logic [ITER_W-1:0]         lim_q, lim_d, iter_q, iter_d;
    logic [ITER_W-1:0]         res_iter_q, res_iter_d;
    logic                      bnd_q, bnd_d;
    logic signed [WIDTH-1:0]   zo_re_q, zo_re_d, zo_im_q, zo_im_d;

    logic signed [W2-1:0]      re_sq, im_sq, re_im, mag, re_next, im_next;

    assign re_sq   = fx_mul(z_re_q, z_re_q);
    assign im_sq   = fx_mul(z_im_q, z_im_q);
    assign re_im   = fx_mul(z_re_q, z_im_q);
    // Magnitude is compared at full width so a large |z| escapes before any wrap.
    assign mag     = re_sq + im_sq;
    assign re_next = re_sq - im_sq + W2'(c_re_q);
    assign im_next = re_im + re_im + W2'(c_im_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            z_re_q     <= '0;
            z_im_q     <= '0;
            c_re_q     <= '0;
            c_im_q     <= '0;
            lim_q      <= '0;
            iter_q     <= '0;
            res_iter_q <= '0;
            bnd_q      <= 1'b0;
            zo_re_q    <= '0;
            zo_im_q    <= '0;
        end else begin
            state_q    <= state_d;
            z_re_q     <= z_re_d;
            z_im_q     <= z_im_d;
            c_re_q     <= c_re_d;
            c_im_q     <= c_im_d;
            lim_q      <= lim_d;
            iter_q     <= iter_d;
            res_iter_q <= res_iter_d;
            bnd_q      <= bnd_d;
            zo_re_q    <= zo_re_d;
            zo_im_q    <= zo_im_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        z_re_d     = z_re_q;
        z_im_d     = z_im_q;
        c_re_d     = c_re_q;
        c_im_d     = c_im_q;
        lim_d      = lim_q;
        iter_d     = iter_q;
        res_iter_d = res_iter_q;
        bnd_d      = bnd_q;
        zo_re_d    = zo_re_q;
        zo_im_d    = zo_im_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = ITER;
                    z_re_d  = i_p_re;
                    z_im_d  = i_p_im;
                    c_re_d  = i_mode ? i_k_re : i_p_re;
                    c_im_d  = i_mode ? i_k_im : i_p_im;
                    lim_d   = i_max_iter;
                    iter_d  = '0;
                end
            end
            ITER: begin
                // Escape outranks the limit when both hold in the same cycle.
                if (mag > ESC_LIM) begin
                    state_d    = DONE;
                    res_iter_d = iter_q;
                    bnd_d      = 1'b0;
                    zo_re_d    = z_re_q;
                    zo_im_d    = z_im_q;
                end else if (iter_q == lim_q) begin
                    state_d    = DONE;
                    res_iter_d = iter_q;
                    bnd_d      = 1'b1;
                    zo_re_d    = z_re_q;
                    zo_im_d    = z_im_q;
                end else begin
                    z_re_d = wrap_w(re_next);
                    z_im_d = wrap_w(im_next);
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_iter    = res_iter_q;
    assign o_bounded = bnd_q;
`ifdef MANDEL_ZOUT_EN
    assign o_z_re    = zo_re_q;
    assign o_z_im    = zo_im_q;
`endif

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Directed table-driven bench for mandelbrot_engine, plus backpressure and mid-run reset sequences.
module tb_mandelbrot_engine;

    logic clk = 1'b0;
    logic rst;
    logic i_valid, i_mode, i_ready;
    logic signed [15:0] i_p_re, i_p_im, i_k_re, i_k_im;
    logic [7:0] i_max_iter;
    logic o_ready, o_valid, o_bounded;
    logic [7:0] o_iter;
`ifdef MANDEL_ZOUT_EN
    logic signed [15:0] o_z_re, o_z_im;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mandelbrot_engine #(.WIDTH(16), .FRAC(12), .ITER_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mode     (i_mode),
        .i_p_re     (i_p_re),
        .i_p_im     (i_p_im),
        .i_k_re     (i_k_re),
        .i_k_im     (i_k_im),
        .i_max_iter (i_max_iter),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_iter     (o_iter),
        .o_bounded  (o_bounded)
`ifdef MANDEL_ZOUT_EN
        ,
        .o_z_re     (o_z_re),
        .o_z_im     (o_z_im)
`endif
    );

    typedef struct {
        logic               mode;
        logic signed [15:0] p_re, p_im, k_re, k_im;
        logic [7:0]         lim;
        int                 exp_iter;
        logic               exp_bnd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req)
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        else
            passed++;
    endtask

    // Drive one request, accept it, then scramble the inputs to prove they are not resampled.
    task automatic send(input logic mode, input logic signed [15:0] pr, pi, kr, ki,
                        input logic [7:0] lim);
        @(negedge clk);
        chk("ready_before_req", o_ready, 1);
        i_valid = 1'b1; i_mode = mode; i_max_iter = lim;
        i_p_re = pr; i_p_im = pi; i_k_re = kr; i_k_im = ki;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; i_mode = ~mode; i_max_iter = 8'd3;
        i_p_re = 16'sd20000; i_p_im = -16'sd20000; i_k_re = 16'sd7000; i_k_im = 16'sd7000;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_result(input int exp_iter);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("valid_drop", o_valid, 0);
        chk("ready_return", o_ready, 1);
        chk("iter_held_idle", o_iter, exp_iter);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0,      16'sd0, 16'sd0,      16'sd0, 16'sd0, 8'd255, 255, 1'b1};
        vecs[1] = '{1'b0,   16'sd8192, 16'sd0,      16'sd0, 16'sd0, 8'd255,   1, 1'b0};
        vecs[2] = '{1'b0,  -16'sd8192, 16'sd0,      16'sd0, 16'sd0, 8'd10,   10, 1'b1};
        vecs[3] = '{1'b0,  -16'sd8192, 16'sd0,      16'sd0, 16'sd0, 8'd0,     0, 1'b1};
        vecs[4] = '{1'b0,   16'sd4096, 16'sd0,      16'sd0, 16'sd0, 8'd50,    2, 1'b0};
        vecs[5] = '{1'b1,   16'sd4096, 16'sd0,  -16'sd4096, 16'sd0, 8'd50,   50, 1'b1};

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_mode = 1'b0;
        i_p_re = '0; i_p_im = '0; i_k_re = '0; i_k_im = '0; i_max_iter = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_iter", o_iter, 0);
        chk("rst_bounded", o_bounded, 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].mode, vecs[v].p_re, vecs[v].p_im, vecs[v].k_re, vecs[v].k_im, vecs[v].lim);
            wait_valid(n);
            chk($sformatf("v%0d_latency", v), n, vecs[v].exp_iter + 1);
            chk($sformatf("v%0d_iter", v), o_iter, vecs[v].exp_iter);
            chk($sformatf("v%0d_bounded", v), o_bounded, vecs[v].exp_bnd);
            chk($sformatf("v%0d_ready_done", v), o_ready, 0);
            release_result(vecs[v].exp_iter);
        end

        // Abort the origin case mid-ITER; the previous Julia result must be held until then.
        send(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 8'd255);
        repeat (20) @(negedge clk);
        chk("iter_held_iter", o_iter, 50);
        chk("bnd_held_iter", o_bounded, 1);
        chk("ready_in_iter", o_ready, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", o_ready, 1);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_iter", o_iter, 0);
        chk("midrst_bounded", o_bounded, 0);
        @(negedge clk);
        rst = 1'b0;

        // Backpressure with a competing request held on i_valid during DONE.
        send(1'b0, 16'sd8192, 16'sd0, 16'sd0, 16'sd0, 8'd255);
        wait_valid(n);
        chk("bp_latency", n, 2);
`ifdef MANDEL_ZOUT_EN
        chk("bp_z_re", o_z_re, 24576);
        chk("bp_z_im", o_z_im, 0);
`endif
        i_valid = 1'b1; i_mode = 1'b0; i_p_re = '0; i_p_im = '0; i_max_iter = 8'd255;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", c), o_valid, 1);
            chk($sformatf("bp%0d_iter", c), o_iter, 1);
            chk($sformatf("bp%0d_bounded", c), o_bounded, 0);
            chk($sformatf("bp%0d_ready", c), o_ready, 0);
        end
        i_valid = 1'b0;
        release_result(1);
        @(negedge clk);
        chk("bp_no_ghost_start", o_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
